// File: rtl/oka_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oka_pkg
// Purpose : Shared types and constants for the split carry-less multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package oka_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Phase encoding: bit 1 selects the odd half of A, bit 0 the odd half of B.
    localparam logic [1:0] PH_EE = 2'd0;
    localparam logic [1:0] PH_EO = 2'd1;
    localparam logic [1:0] PH_OE = 2'd2;
    localparam logic [1:0] PH_OO = 2'd3;

    function automatic int prod_w(input int n);
        return 2 * n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_mul_half.sv
`default_nettype none
// ============================================================================
// Module  : gf2_mul_half
// Purpose : Combinational schoolbook carry-less multiplier, H x H -> 2H-1 bits.
// Revision: 1.0 - initial release
// ============================================================================
module gf2_mul_half #(
    parameter int H = 2
) (
    input  logic [H-1:0]   i_a,
    input  logic [H-1:0]   i_b,
    output logic [2*H-2:0] o_p
);

    always_comb begin
        o_p = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                o_p[i+j] = o_p[i+j] ^ (i_a[i] & i_b[j]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oka_split_mul.sv
`default_nettype none
// ============================================================================
// Module  : oka_split_mul
// Purpose : Carry-less N x N multiplier built from four even/odd half products
//           computed sequentially on one shared half-width multiplier.
// Revision: 1.0 - initial release
// ============================================================================
module oka_split_mul
    import oka_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [prod_w(N)-1:0] p,
    output logic                 busy
);

    localparam int H  = N / 2;
    localparam int PW = prod_w(N);
    localparam int SW = N - 1;

    generate
        if ((N % 2) != 0 || N < 4) begin : g_n_check
            $error("oka_split_mul: N must be even and at least 4");
        end
    endgenerate

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_phase;
    logic [N-1:0]  r_a, r_b;
    logic [PW-1:0] r_acc;
    logic          r_out_valid;

    logic [H-1:0]  w_ae, w_ao, w_be, w_bo;
    logic [H-1:0]  w_op_a, w_op_b;
    logic [SW-1:0] w_sub;
    logic [PW-1:0] w_spread, w_place;
    logic [1:0]    w_off;

    generate
        for (genvar i = 0; i < H; i++) begin : g_split
            assign w_ae[i] = r_a[2*i];
            assign w_ao[i] = r_a[2*i+1];
            assign w_be[i] = r_b[2*i];
            assign w_bo[i] = r_b[2*i+1];
        end
    endgenerate

    assign w_op_a = (r_phase == PH_OE || r_phase == PH_OO) ? w_ao : w_ae;
    assign w_op_b = (r_phase == PH_EO || r_phase == PH_OO) ? w_bo : w_be;

    gf2_mul_half #(.H(H)) u_mul (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_sub)
    );

    // Half-product coefficient i lands on bit 2i, then shifts by the parity sum.
    always_comb begin
        w_spread = '0;
        for (int i = 0; i < SW; i++) begin
            w_spread[2*i] = w_sub[i];
        end
        case (r_phase)
            PH_EE:        w_off = 2'd0;
            PH_EO, PH_OE: w_off = 2'd1;
            default:      w_off = 2'd2;
        endcase
        w_place = w_spread << w_off;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = MUL;
            MUL:     if (r_phase == PH_OO) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_phase     <= PH_EE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_phase <= PH_EE;
                    end
                end
                MUL: begin
                    r_acc   <= r_acc ^ w_place;
                    r_phase <= r_phase + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign p         = r_acc;

endmodule
`default_nettype wire

// File: doc/oka_split_mul.md
OKA_SPLIT_MUL -- requirements
Module: oka_split_mul

Interface
REQ-001 Parameter: N, default 4, operand width in bits; SHALL be even and at least 4.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand pair a, b is valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: a  input  N  operand A, a GF(2) polynomial; bit i is the coefficient of x^i.
REQ-007 Port: b  input  N  operand B, same encoding as a.
REQ-008 Port: out_valid  output  1  p holds a completed product.
REQ-009 Port: out_ready  input  1  consumer accepts p.
REQ-010 Port: p  output  2N-1  carry-less product of a and b.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 Operand split on accept:
- Ae = a even-index bits, Ao = a odd-index bits, each N/2 bits.
- Be and Bo are the same split of b.
- Both operands SHALL be registered.
REQ-013 One shared combinational N/2 x N/2 carry-less multiplier SHALL produce one (N-1)-bit sub-product per cycle.
REQ-014 States: IDLE, MUL, DONE; a 2-bit phase counter runs only in MUL.
REQ-015 IDLE:
- in_ready=1.
- in_valid=1 at an edge: latch a and b, clear the accumulator, phase=0, go to MUL.
REQ-016 MUL: one sub-product per phase, XOR-accumulated into a (2N-1)-bit accumulator, coefficient index i from 0 to N-2:
- phase 0: Ae*Be into bit 2i.
- phase 1: Ae*Bo into bit 2i+1.
- phase 2: Ao*Be into bit 2i+1.
- phase 3: Ao*Bo into bit 2i+2.
REQ-017 Phase 3 SHALL go to DONE; phases 0-2 increment the phase counter.
REQ-018 DONE:
- out_valid=1 and p=accumulator.
- p SHALL stay stable while out_ready=0.
- out_ready=1 at an edge: go to IDLE.
REQ-019 Latency: out_valid SHALL assert exactly 4 cycles after the accept edge.
REQ-020 Throughput: one product every 6 cycles with out_ready held high.
REQ-021 in_ready SHALL be 0 in MUL and DONE; in_valid there SHALL be ignored and SHALL NOT disturb a, b, the accumulator or the phase counter.
REQ-022 No accept in the cycle of a DONE->IDLE transition; the next accept is at the earliest on the following edge.
REQ-023 out_valid SHALL be registered; in_ready and busy SHALL be decoded from state only, with no combinational path from in_valid or out_ready to any output.
REQ-024 p SHALL be the accumulator in every state; its value is defined only while out_valid=1.
REQ-025 The result SHALL equal the full carry-less product a*b over GF(2), with no reduction polynomial applied.

Reset
REQ-026 rst_n low SHALL immediately force:
- state=IDLE, phase=0.
- accumulator, a and b registers all 0.
- out_valid=0, busy=0, in_ready=1.
REQ-027 Reset asserted during MUL or DONE SHALL abort the operation with no out_valid pulse; operation resumes at the first edge after deassertion.

Structure
REQ-028 Shared package oka_pkg SHALL hold:
- the state enum (IDLE, MUL, DONE);
- the phase constants PH_EE, PH_EO, PH_OE, PH_OO;
- a width helper function for 2N-1.
REQ-029 Sub-module gf2_mul_half SHALL be the combinational schoolbook carry-less multiplier (N/2 x N/2 to N-1 bits), instantiated once.
REQ-030 The accumulator placement logic (REQ-016) SHALL stay in oka_split_mul and SHALL match the even/odd overlap recombination of the team's overlap modules bit for bit.

Verification
REQ-031 N=4, a=4'b1011, b=4'b0110, out_ready=1 -> out_valid 4 cycles after accept, p=7'h3A, then in_ready=1 the next cycle.
REQ-032 N=4, a=4'hF, b=4'hF -> p=7'h55; also a=4'h0, b=4'hF -> p=7'h00.
REQ-033 N=4, a=4'h1, b=4'h9, out_ready held 0 for 10 cycles -> p=7'h09 held stable with out_valid=1 and in_ready=0 throughout; accepted on the edge where out_ready rises.
REQ-034 N=4, in_valid toggled with new operands during MUL -> result unchanged versus the first accepted pair and no extra accept.
REQ-035 rst_n pulsed low during phase 2 -> outputs take reset values immediately, no out_valid; the next transaction a=4'h3, b=4'h3 -> p=7'h05.
REQ-036 N=8, random regression of 1000 pairs against a bitwise carry-less reference model -> all match; back-to-back spacing of 6 cycles with out_ready=1.
